fifo_uart_tx: RTL

//  Drain stage directly downstream of fifo: pops words while fifo is non-empty.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_uart_tx_if.sv | 21 ++
 rtl/uart_baud_gen.sv | 28 ++
 rtl/fifo_uart_tx.sv | 104 ++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo drain / UART transmit slice.
// Holds the FSM state encodings and the default word width.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LATCH = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } uart_state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between a fifo and the UART drain stage.
// The drain stage is the master: it issues pops and consumes data.
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = fifo_pkg::DEFAULT_DATA_WIDTH
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and ticks on the wrap.
// tick_early flags the cycle before the wrap so the caller can register a last-cycle pulse.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick,
    output logic tick_early
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick       = (count == CNT_W'(CLKS_PER_BIT - 1));
    assign tick_early = (count == CNT_W'(CLKS_PER_BIT - 2));
endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from an upstream fifo and serialises each one as UART 8N1, LSB first.
// Every pin-facing output is a flop loaded from the next-state decode, so it tracks the state register exactly.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = fifo_pkg::DEFAULT_DATA_WIDTH,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);
    import fifo_pkg::*;

    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

    uart_state_t           state, state_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [BIT_W-1:0]      bit_idx, bit_idx_next;
    logic                  baud_clear, tick, tick_early;
    logic                  tx_d, rd_en_d, busy_d, tx_done_d;
    logic                  rd_en_q;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (baud_clear),
        .tick       (tick),
        .tick_early (tick_early)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            tx        <= 1'b1;
            rd_en_q   <= 1'b0;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_idx   <= bit_idx_next;
            tx        <= tx_d;
            rd_en_q   <= rd_en_d;
            busy      <= busy_d;
            tx_done   <= tx_done_d;
        end
    end

    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx;

        case (state)
            ST_IDLE: begin
                if (en && !fifo.fifo_empty) state_next = ST_READ;
            end
            ST_READ: begin
                state_next = ST_LATCH;
            end
            ST_LATCH: begin
                shift_next = fifo.fifo_data;
                state_next = ST_START;
            end
            ST_START: begin
                bit_idx_next = '0;
                if (tick) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    shift_next   = shift_reg >> 1;
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == BIT_W'(DATA_WIDTH - 1)) state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) state_next = (en && !fifo.fifo_empty) ? ST_READ : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Restart the bit period on every state entry so no phase carries across states.
        baud_clear = (state_next != state) || (state == ST_IDLE);

        tx_d = 1'b1;
        if (state_next == ST_START)     tx_d = 1'b0;
        else if (state_next == ST_DATA) tx_d = shift_next[0];

        rd_en_d   = (state_next == ST_READ);
        busy_d    = (state_next != ST_IDLE);
        tx_done_d = (state == ST_STOP) && tick_early;
    end

    assign fifo.fifo_rd_en = rd_en_q;
endmodule
